// File: rtl/core_seq.sv
// core_seq: instruction sequencer for `core`. A single `start` pulse walks
// every kernel position through weight L0 fill, PE load, activation L0 fill,
// execute, drain and OFIFO-to-pmem, then (optionally) an accumulation pass.
// Optional feature macro: CORE_SEQ_ACC_EN builds the accumulation (ACC) phase.
// `inst` is registered and is computed from the next state, so the word on
// `inst` always belongs to the state entered at the same edge.
// Geometry parameters are assumed >= 2 (o_dim, k_dim) so counter widths are
// non-zero.
//
// OFIFO handshake: `ofifo_valid` is sampled at each clock edge while the
// sequencer is in (or entering) ORD. When it is high at that edge, the word
// issued for the following cycle is a pmem write with ofifo_rd=1 and the
// write index advances; when it is low, the following cycle carries the
// idle word and the index holds.
module core_seq #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int i_dim   = 6,
  parameter int o_dim   = 4,
  parameter int k_dim   = 3,
  parameter int gap     = 10,
  parameter int wt_base = 'h400
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             ofifo_valid,
  output logic [33:0]                      inst,
  output logic                             busy,
  output logic                             done,
  output logic                             out_valid,
  output logic [$clog2(k_dim*k_dim)-1:0]   kij,
  output logic [3:0]                       state_dbg
);

  localparam int LEN_NIJ = i_dim * i_dim;
  localparam int LEN_KIJ = k_dim * k_dim;
  localparam int DRAIN   = row + col;
  localparam int ACC_LEN = LEN_KIJ + 2;
  localparam int M1      = (LEN_NIJ > DRAIN) ? LEN_NIJ : DRAIN;
  localparam int M2      = (M1 > gap) ? M1 : gap;
  localparam int M3      = (M2 > col) ? M2 : col;
  localparam int M4      = (M3 > ACC_LEN) ? M3 : ACC_LEN;
  localparam int CW      = $clog2(M4 + 1);
  localparam int KW      = $clog2(LEN_KIJ);
  localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;

  typedef enum logic [3:0] {
    S_IDLE, S_LAUNCH, S_WL0, S_GAP1, S_KLD, S_GAP2, S_XL0,
    S_GAP3, S_EXE, S_DRN, S_ORD, S_ACC, S_DONE
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d, j_issue;
  logic [KW-1:0]   kij_d;
  logic            ord_wr;
  logic [33:0]     inst_d;
  logic            busy_d, done_d, ov_d;
  int              k_i, c_i, j_i;
  logic            acc_b, cen_p, wen_p, cen_x, wen_x;
  logic            ofifo_rd, l0_rd, l0_wr, exe, load;
  logic [10:0]     a_p, a_x;

`ifdef CORE_SEQ_ACC_EN
  localparam int OW = $clog2(o_dim);
  localparam int DW = $clog2(k_dim);
  logic [OW-1:0]   ox, oy, ox_d, oy_d;
  logic [DW-1:0]   kx, ky, kx_d, ky_d;
  logic            ov_q;
  int              ox_i, oy_i, kx_i, ky_i;
`endif

  assign state_dbg = state;

  // Next state and counters; ORD also decides whether the next word is a write.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    kij_d   = kij;
    ord_wr  = 1'b0;
    j_issue = '0;
`ifdef CORE_SEQ_ACC_EN
    ox_d = ox;
    oy_d = oy;
    kx_d = kx;
    ky_d = ky;
`endif
    case (state)
      S_IDLE: if (start) begin
        state_d = S_LAUNCH;
        cnt_d   = '0;
        kij_d   = '0;
      end
      S_LAUNCH: begin
        state_d = S_WL0;
        cnt_d   = '0;
      end
      S_WL0:  if (cnt == CW'(col - 1))     begin state_d = S_GAP1; cnt_d = '0; end else cnt_d = cnt + 1'b1;
      S_GAP1: if (cnt == CW'(gap - 1))     begin state_d = S_KLD;  cnt_d = '0; end else cnt_d = cnt + 1'b1;
      S_KLD:  if (cnt == CW'(col - 1))     begin state_d = S_GAP2; cnt_d = '0; end else cnt_d = cnt + 1'b1;
      S_GAP2: if (cnt == CW'(gap - 1))     begin state_d = S_XL0;  cnt_d = '0; end else cnt_d = cnt + 1'b1;
      S_XL0:  if (cnt == CW'(LEN_NIJ - 1)) begin state_d = S_GAP3; cnt_d = '0; end else cnt_d = cnt + 1'b1;
      S_GAP3: if (cnt == CW'(gap - 1))     begin state_d = S_EXE;  cnt_d = '0; end else cnt_d = cnt + 1'b1;
      S_EXE:  if (cnt == CW'(LEN_NIJ - 1)) begin state_d = S_DRN;  cnt_d = '0; end else cnt_d = cnt + 1'b1;
      S_DRN: begin
        if (cnt == CW'(DRAIN - 1)) begin
          state_d = S_ORD;
          ord_wr  = ofifo_valid;
          cnt_d   = ofifo_valid ? CW'(1) : '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      // In ORD, cnt counts words already issued.
      S_ORD: begin
        if (cnt == CW'(LEN_NIJ)) begin
          cnt_d = '0;
          if (kij == KW'(LEN_KIJ - 1)) begin
`ifdef CORE_SEQ_ACC_EN
            state_d = S_ACC;
            ox_d = '0;
            oy_d = '0;
            kx_d = '0;
            ky_d = '0;
`else
            state_d = S_DONE;
`endif
          end else begin
            kij_d   = kij + 1'b1;
            state_d = S_WL0;
          end
        end else if (ofifo_valid) begin
          ord_wr  = 1'b1;
          j_issue = cnt;
          cnt_d   = cnt + 1'b1;
        end
      end
`ifdef CORE_SEQ_ACC_EN
      // cnt is the step within one output; kx/ky follow it for the read steps.
      S_ACC: begin
        if (cnt == CW'(ACC_LEN - 1)) begin
          cnt_d = '0;
          kx_d  = '0;
          ky_d  = '0;
          if (ox == OW'(o_dim - 1)) begin
            ox_d = '0;
            if (oy == OW'(o_dim - 1)) begin
              oy_d    = '0;
              state_d = S_DONE;
            end else begin
              oy_d = oy + 1'b1;
            end
          end else begin
            ox_d = ox + 1'b1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
          if (cnt < CW'(LEN_KIJ - 1)) begin
            if (kx == DW'(k_dim - 1)) begin
              kx_d = '0;
              ky_d = ky + 1'b1;
            end else begin
              kx_d = kx + 1'b1;
            end
          end
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Instruction word and status flags for the state being entered.
  always_comb begin
    acc_b    = 1'b0;
    cen_p    = 1'b1;
    wen_p    = 1'b1;
    a_p      = '0;
    cen_x    = 1'b1;
    wen_x    = 1'b1;
    a_x      = '0;
    ofifo_rd = 1'b0;
    l0_rd    = 1'b0;
    l0_wr    = 1'b0;
    exe      = 1'b0;
    load     = 1'b0;
    ov_d     = 1'b0;
    k_i      = int'(kij_d);
    c_i      = int'(cnt_d);
    j_i      = int'(j_issue);
`ifdef CORE_SEQ_ACC_EN
    ox_i = int'(ox_d);
    oy_i = int'(oy_d);
    kx_i = int'(kx_d);
    ky_i = int'(ky_d);
`endif
    case (state_d)
      S_WL0: begin
        cen_x = 1'b0;
        l0_wr = 1'b1;
        a_x   = 11'(wt_base + k_i * col + c_i);
      end
      S_KLD: begin
        l0_rd = 1'b1;
        load  = 1'b1;
      end
      S_XL0: begin
        cen_x = 1'b0;
        l0_wr = 1'b1;
        a_x   = 11'(c_i);
      end
      S_EXE: begin
        l0_rd = 1'b1;
        exe   = 1'b1;
      end
      S_ORD: if (ord_wr) begin
        ofifo_rd = 1'b1;
        cen_p    = 1'b0;
        wen_p    = 1'b0;
        a_p      = 11'(k_i * LEN_NIJ + j_i);
      end
`ifdef CORE_SEQ_ACC_EN
      S_ACC: begin
        if (cnt_d < CW'(LEN_KIJ)) begin
          cen_p = 1'b0;
          a_p   = 11'(c_i * LEN_NIJ + (oy_i + ky_i) * i_dim + ox_i + kx_i);
        end
        acc_b = (cnt_d != '0) && (cnt_d <= CW'(LEN_KIJ));
        ov_d  = (cnt_d == CW'(ACC_LEN - 1));
      end
`endif
      default: ;
    endcase
    inst_d = {acc_b, cen_p, wen_p, a_p, cen_x, wen_x, a_x,
              ofifo_rd, 1'b0, 1'b0, l0_rd, l0_wr, exe, load};
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  // State, counters and registered outputs; reset aborts any run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      kij   <= '0;
      inst  <= IDLE_WORD;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      kij   <= kij_d;
      inst  <= inst_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

`ifdef CORE_SEQ_ACC_EN
  // Accumulation-phase position counters and the out_valid register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ox   <= '0;
      oy   <= '0;
      kx   <= '0;
      ky   <= '0;
      ov_q <= 1'b0;
    end else begin
      ox   <= ox_d;
      oy   <= oy_d;
      kx   <= kx_d;
      ky   <= ky_d;
      ov_q <= ov_d;
    end
  end
  assign out_valid = ov_q;
`else
  assign out_valid = 1'b0;
`endif

endmodule

// File: tb/tb_core_seq.sv
// Directed testbench for core_seq: reset values, full run timing and pmem
// write map, kij 2 weight fill and PE load, OFIFO handshake stalls, reset
// abort mid-EXE, restart, and (when built) the accumulation read pattern.
module tb_core_seq;

  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ofifo_valid;
  logic [33:0] inst;
  logic        busy;
  logic        done;
  logic        out_valid;
  logic [3:0]  kij;
  logic [3:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  logic [10:0] exp_q[$];
  logic [10:0] rd_log[0:143];
  int          rd_n = 0;
  int          wr_n = 0;
  int          ov_n = 0;
  logic        mon_en = 1'b0;
  logic        v_s = 1'b0;
  logic        prev_rd = 1'b0;

  // Clock and reset
  always #5 clk = ~clk;

  core_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .busy        (busy),
    .done        (done),
    .out_valid   (out_valid),
    .kij         (kij),
    .state_dbg   (state_dbg)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [33:0] wl0(input logic [10:0] a);
    logic [33:0] w;
    w = IDLE_W;
    w[19] = 1'b0;
    w[17:7] = a;
    w[2] = 1'b1;
    return w;
  endfunction

  // ofifo_valid as the DUT sees it at each edge
  always @(posedge clk) v_s <= ofifo_valid;

  // Scoreboard: pmem writes against exp_q, handshake and acc-lag rules
  always @(negedge clk) begin
    if (mon_en) begin
      check("rd_iff_wr", {63'd0, inst[6]}, {63'd0, inst[32:31] == 2'b00});
      check("ififo_bits_zero", {62'd0, inst[5:4]}, 64'd0);
      check("acc_lags_read", {63'd0, inst[33]}, {63'd0, prev_rd});
      if (inst[32:31] == 2'b00) begin
        wr_n++;
        check("wr_in_valid_cycle", {63'd0, v_s}, 64'd1);
        check("wr_q_nonempty", {63'd0, exp_q.size() > 0}, 64'd1);
        if (exp_q.size() > 0) check("wr_addr", {53'd0, inst[30:20]}, {53'd0, exp_q.pop_front()});
      end
      if (inst[32:31] == 2'b01) begin
        if (rd_n < 144) rd_log[rd_n] = inst[30:20];
        rd_n++;
      end
      if (out_valid) ov_n++;
      prev_rd = (inst[32:31] == 2'b01);
    end
  end

  initial begin
    int t;
    int done_t;
    int loads;
    int busy_low;
    int done_seen;
    reset = 1'b0;
    start = 1'b0;
    ofifo_valid = 1'b1;
    #12;
    check("rst_inst", {30'd0, inst}, {30'd0, IDLE_W});
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_kij", {60'd0, kij}, 64'd0);
    tick();
    reset = 1'b1;
    tick();

    // Run 1: ofifo_valid held high, start re-pulsed while busy
    for (int i = 0; i < 324; i++) exp_q.push_back(11'(i));
    mon_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("launch_busy", {63'd0, busy}, 64'd1);
    check("launch_idle", {30'd0, inst}, {30'd0, IDLE_W});
    tick();
    check("first_wl0", {30'd0, inst}, {30'd0, wl0(11'h400)});
    check("first_kij", {60'd0, kij}, 64'd0);
    t = 0;
    done_t = -1;
    loads = 0;
    busy_low = 0;
    while (done_t < 0 && t < 2500) begin
      if (t >= 340 && t < 348) begin
        check("k2_wl0", {30'd0, inst}, {30'd0, wl0(11'(32'h410 + t - 340))});
        check("k2_kij", {60'd0, kij}, 64'd2);
      end
      if (t == 357) check("k2_gap1_end", {30'd0, inst}, {30'd0, IDLE_W});
      if (t == 358) check("k2_kld_first", {30'd0, inst}, {30'd0, IDLE_W | 34'h9});
      if (t >= 340 && t < 510 && inst[0]) loads++;
      if (!busy) busy_low++;
      start = (t == 100);
      tick();
      t++;
      if (done) done_t = t;
    end
    start = 1'b0;
`ifdef CORE_SEQ_ACC_EN
    check("done_latency", 64'(done_t), 64'd1706);
`else
    check("done_latency", 64'(done_t), 64'd1530);
`endif
    check("k2_load_cycles", 64'(loads), 64'd8);
    check("busy_during_run", 64'(busy_low), 64'd0);
    check("busy_at_done", {63'd0, busy}, 64'd0);
    tick();
    check("done_one_cycle", {63'd0, done}, 64'd0);
    check("idle_after_done", {30'd0, inst}, {30'd0, IDLE_W});
    check("wr_count", 64'(wr_n), 64'd324);
    check("wr_all_seen", 64'(exp_q.size()), 64'd0);
`ifdef CORE_SEQ_ACC_EN
    check("out_valid_count", 64'(ov_n), 64'd16);
    check("acc_read_count", 64'(rd_n), 64'd144);
    check("acc_o5_k4", {53'd0, rd_log[5*9+4]}, 64'd158);
    check("acc_o0_k0", {53'd0, rd_log[0]}, 64'd0);
    check("acc_o15_k8", {53'd0, rd_log[143]}, 64'd323);
    for (int o = 0; o < 16; o++) begin
      for (int k = 0; k < 9; k++) begin
        int a;
        a = k * 36 + ((o / 4) + (k / 3)) * 6 + (o % 4) + (k % 3);
        check("acc_addr", {53'd0, rd_log[o*9+k]}, 64'(a));
      end
    end
`else
    check("out_valid_count", 64'(ov_n), 64'd0);
    check("acc_read_count", 64'(rd_n), 64'd0);
`endif

    // Run 2: ofifo_valid toggled, then reset mid-EXE of kij 3
    wr_n = 0;
    for (int i = 0; i < 324; i++) exp_q.push_back(11'(i));
    start = 1'b1;
    tick();
    start = 1'b0;
    t = 0;
    done_seen = 0;
    while (!(kij == 4'd3 && inst[1]) && t < 3000) begin
      ofifo_valid = (t % 3) != 0;
      tick();
      t++;
      if (done) done_seen++;
    end
    ofifo_valid = 1'b1;
    check("reach_k3_exe", {63'd0, t < 3000}, 64'd1);
    for (int i = 0; i < 5; i++) tick();
    check("pre_abort_exe", {63'd0, inst[1]}, 64'd1);
    check("pre_abort_kij", {60'd0, kij}, 64'd3);
    check("stall_wr_count", 64'(wr_n), 64'd108);
    check("stall_wr_left", 64'(exp_q.size()), 64'd216);
    check("no_done_run2", 64'(done_seen), 64'd0);
    #2;
    reset = 1'b0;
    #1;
    check("abort_inst", {30'd0, inst}, {30'd0, IDLE_W});
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_kij", {60'd0, kij}, 64'd0);
    exp_q.delete();
    tick();
    reset = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
    check("abort_stays_idle", {30'd0, inst}, {30'd0, IDLE_W});

    // Run 3: fresh start after abort begins again at kij 0
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("restart_wl0", {30'd0, inst}, {30'd0, wl0(11'h400)});
    check("restart_kij", {60'd0, kij}, 64'd0);
    for (int i = 0; i < 7; i++) tick();
    check("restart_wl0_last", {30'd0, inst}, {30'd0, wl0(11'h407)});
    tick();
    check("restart_gap1", {30'd0, inst}, {30'd0, IDLE_W});
    mon_en = 1'b0;
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
